// File: rtl/ctrl_reg_desp.sv
// Command sequencer for the 4-bit universal shift register: turns one REQ
// (load / shift N / rotate N) into exactly N enabled register clock edges.
module ctrl_reg_desp #(
    parameter int ANCHO = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ,
    input  logic [1:0]       OP,
    input  logic             DIR_IN,
    input  logic [CNT_W-1:0] CNT,
    input  logic [ANCHO-1:0] DATO,
    input  logic             S_SER,
    output logic             BUSY,
    output logic             DONE,
    output logic [1:0]       MODO,
    output logic             DIR,
    output logic             S_IN,
    output logic             ENB,
    output logic [ANCHO-1:0] D
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               dir_in_q, dir_in_d;
    logic               s_ser_q, s_ser_d;
    logic [ANCHO-1:0]   dato_q, dato_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               enb_q, enb_d;
    logic [1:0]         modo_q, modo_d;
    logic               dir_q, dir_d;
    logic               s_in_q, s_in_d;
    logic [ANCHO-1:0]   d_q, d_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        dir_in_d = dir_in_q;
        s_ser_d  = s_ser_q;
        dato_d   = dato_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        enb_d    = 1'b0;
        modo_d   = modo_q;
        dir_d    = dir_q;
        s_in_d   = s_in_q;
        d_d      = d_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (REQ) begin
                    op_d     = OP;
                    dir_in_d = DIR_IN;
                    cnt_d    = CNT;
                    dato_d   = DATO;
                    s_ser_d  = S_SER;
                    busy_d   = 1'b1;
                    // Outputs are registered, so the first enabled cycle is
                    // set up on the accepting edge itself.
                    if (OP[1]) begin
                        state_d = LOAD;
                        enb_d   = 1'b1;
                        modo_d  = 2'b10;
                        d_d     = DATO;
                    end else if (CNT == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = STEP;
                        enb_d   = 1'b1;
                        modo_d  = OP;
                        dir_d   = DIR_IN;
                        s_in_d  = S_SER;
                    end
                end
            end
            LOAD: begin
                state_d = FIN;
                done_d  = 1'b1;
            end
            STEP: begin
                cnt_d  = cnt_q - 1'b1;
                modo_d = op_q;
                dir_d  = dir_in_q;
                s_in_d = s_ser_q;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    enb_d = 1'b1;
                end
            end
            FIN: begin
                // A zero-count command enters FIN without DONE set; it
                // raises DONE one cycle later so latency matches the others.
                if (done_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            dir_in_q <= 1'b0;
            s_ser_q  <= 1'b0;
            dato_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            enb_q    <= 1'b0;
            modo_q   <= '0;
            dir_q    <= 1'b0;
            s_in_q   <= 1'b0;
            d_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            dir_in_q <= dir_in_d;
            s_ser_q  <= s_ser_d;
            dato_q   <= dato_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            enb_q    <= enb_d;
            modo_q   <= modo_d;
            dir_q    <= dir_d;
            s_in_q   <= s_in_d;
            d_q      <= d_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign ENB  = enb_q;
    assign MODO = modo_q;
    assign DIR  = dir_q;
    assign S_IN = s_in_q;
    assign D    = d_q;

endmodule

// File: tb/tb_ctrl_reg_desp.sv
// Self-checking bench for ctrl_reg_desp: drives commands into the sequencer,
// models the attached shift register, and scores each DONE against a queue.
module tb_ctrl_reg_desp;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       REQ = 1'b0;
    logic [1:0] OP = 2'b00;
    logic       DIR_IN = 1'b0;
    logic [2:0] CNT = 3'd0;
    logic [3:0] DATO = 4'd0;
    logic       S_SER = 1'b0;
    logic       BUSY, DONE, DIR, S_IN, ENB;
    logic [1:0] MODO;
    logic [3:0] D;

    ctrl_reg_desp #(.ANCHO(4), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP), .DIR_IN(DIR_IN),
        .CNT(CNT), .DATO(DATO), .S_SER(S_SER), .BUSY(BUSY), .DONE(DONE),
        .MODO(MODO), .DIR(DIR), .S_IN(S_IN), .ENB(ENB), .D(D)
    );

    always #5 CLK = ~CLK;

    // Behavioural model of the attached universal shift register.
    logic [3:0] q_model = 4'b0000;
    always @(posedge CLK) begin
        if (ENB) begin
            case (MODO)
                2'b00:   q_model <= DIR ? {S_IN, q_model[3:1]} : {q_model[2:0], S_IN};
                2'b01:   q_model <= DIR ? {q_model[0], q_model[3:1]} : {q_model[2:0], q_model[3]};
                default: q_model <= D;
            endcase
        end
    end

    typedef struct {
        logic [1:0] op;
        logic       dir;
        logic [2:0] cnt;
        logic [3:0] dato;
        logic       ser;
        logic [3:0] exp_q;
    } vec_t;

    typedef struct {
        logic [3:0] q;
        int         enb;
        int         lat;
        logic       ld;
        logic [1:0] modo;
        logic [3:0] d;
        logic       dir;
        logic       ser;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[9];

    int errors = 0;
    int checks = 0;
    int done_count = 0;
    int n_cmds = 0;
    int enb_cnt = 0;
    int lat = 0;
    logic busy_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and run the output monitor there.
    task automatic cycle();
        exp_t e;
        @(negedge CLK);
        if (RST) begin
            busy_prev = 1'b0;
            enb_cnt   = 0;
            lat       = 0;
            return;
        end
        if (BUSY && !busy_prev) begin
            lat     = 0;
            enb_cnt = 0;
        end else if (BUSY) begin
            lat++;
        end
        if (ENB) begin
            enb_cnt++;
            chk("enb_while_busy", BUSY, 1);
            if (sb.size() > 0) begin
                chk("modo", MODO, sb[0].modo);
                if (sb[0].ld) chk("d", D, sb[0].d);
                else begin
                    chk("dir", DIR, sb[0].dir);
                    chk("s_in", S_IN, sb[0].ser);
                end
            end
        end
        if (DONE) begin
            done_count++;
            chk("done_expected", (sb.size() > 0) ? 1 : 0, 1);
            chk("busy_at_done", BUSY, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                $display("txn modo=%0d q=%b enb=%0d lat=%0d", e.modo, q_model, enb_cnt, lat);
                chk("q", q_model, e.q);
                chk("enb_cycles", enb_cnt, e.enb);
                chk("done_latency", lat, e.lat);
            end
        end
        busy_prev = BUSY;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (sb.size() == 0 && !BUSY) begin
                ok = 1;
                break;
            end
        end
        chk("complete", ok, 1);
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.q    = v.exp_q;
        e.ld   = v.op[1];
        e.enb  = v.op[1] ? 1 : int'(v.cnt);
        e.lat  = (v.op[1] || v.cnt == 0) ? 1 : int'(v.cnt);
        e.modo = v.op[1] ? 2'b10 : v.op;
        e.d    = v.dato;
        e.dir  = v.dir;
        e.ser  = v.ser;
        sb.push_back(e);
        n_cmds++;
    endtask

    task automatic drive(input vec_t v);
        OP = v.op; DIR_IN = v.dir; CNT = v.cnt; DATO = v.dato; S_SER = v.ser;
        REQ = 1'b1;
        @(posedge CLK);
        #1;
        REQ = 1'b0;
        OP = 2'($urandom); DIR_IN = 1'($urandom); CNT = 3'($urandom);
        DATO = 4'($urandom); S_SER = 1'($urandom);
    endtask

    initial begin
        vec_t v;
        int gap;

        tbl[0] = '{2'b10, 1'b0, 3'd0, 4'b1010, 1'b0, 4'b1010}; // load
        tbl[1] = '{2'b01, 1'b0, 3'd3, 4'b0000, 1'b0, 4'b0101}; // rotate left 3
        tbl[2] = '{2'b00, 1'b1, 3'd2, 4'b0000, 1'b1, 4'b1101}; // shift right fill 1
        tbl[3] = '{2'b00, 1'b0, 3'd0, 4'b1111, 1'b0, 4'b1101}; // zero count
        tbl[4] = '{2'b01, 1'b0, 3'd7, 4'b0000, 1'b0, 4'b1110}; // rotate 7
        tbl[5] = '{2'b11, 1'b1, 3'd5, 4'b0110, 1'b1, 4'b0110}; // OP=11 is load
        tbl[6] = '{2'b00, 1'b0, 3'd1, 4'b0000, 1'b0, 4'b1100}; // shift left fill 0
        tbl[7] = '{2'b01, 1'b1, 3'd2, 4'b0000, 1'b0, 4'b0011}; // rotate right 2
        tbl[8] = '{2'b00, 1'b1, 3'd5, 4'b0000, 1'b0, 4'b0000}; // shift right 5

        // Reset asserted with REQ pending: nothing accepted, outputs zero.
        REQ = 1'b1; OP = 2'b10; DATO = 4'hF;
        #1 RST = 1'b1;
        #1;
        chk("rst_outputs", {BUSY, DONE, ENB, MODO, DIR, S_IN, D}, 0);
        repeat (3) cycle();
        chk("rst_hold_busy", BUSY, 0);
        chk("rst_hold_enb", ENB, 0);
        REQ = 1'b0;
        RST = 1'b0;
        repeat (2) cycle();
        chk("idle_busy", BUSY, 0);

        for (int i = 0; i < 9; i++) begin
            push_exp(tbl[i]);
            drive(tbl[i]);
            wait_idle();
        end

        // REQ held across completion: second load accepted after one idle cycle.
        v = '{2'b10, 1'b0, 3'd0, 4'b1001, 1'b0, 4'b1001};
        push_exp(v);
        v = '{2'b11, 1'b0, 3'd0, 4'b0110, 1'b0, 4'b0110};
        push_exp(v);
        OP = 2'b10; DATO = 4'b1001; REQ = 1'b1;
        @(posedge CLK);
        #1;
        OP = 2'b11; DATO = 4'b0110;
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (!BUSY) gap++;
            else if (gap > 0) break;
        end
        REQ = 1'b0;
        chk("idle_gap", gap, 1);
        wait_idle();

        // REQ pulsed during STEP must be ignored.
        v = '{2'b01, 1'b0, 3'd3, 4'b0000, 1'b0, 4'b0011};
        push_exp(v);
        drive(v);
        cycle();
        REQ = 1'b1; OP = 2'b10; DATO = 4'b1111;
        cycle();
        REQ = 1'b0;
        wait_idle();
        repeat (4) cycle();
        chk("done_count", done_count, n_cmds);
        chk("q_after_ignored_req", q_model, 4'b0011);

        // Reset mid-STEP of a 5-step rotate: abort, no DONE.
        OP = 2'b01; DIR_IN = 1'b0; CNT = 3'd5; REQ = 1'b1;
        @(posedge CLK);
        #1 REQ = 1'b0;
        cycle();
        cycle();
        chk("enb_before_abort", ENB, 1);
        #2 RST = 1'b1;
        #1;
        chk("abort_enb", ENB, 0);
        chk("abort_outputs", {BUSY, DONE, ENB, MODO, DIR, S_IN, D}, 0);
        repeat (2) cycle();
        RST = 1'b0;
        repeat (8) cycle();
        chk("abort_busy", BUSY, 0);
        chk("abort_no_done", done_count, n_cmds);

        // Sequencer still usable after the abort.
        v = '{2'b10, 1'b0, 3'd0, 4'b0101, 1'b0, 4'b0101};
        push_exp(v);
        drive(v);
        wait_idle();
        chk("final_done_count", done_count, n_cmds);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_reg_desp.md
Name: ctrl_reg_desp

Overview:
Command sequencer for the 4-bit universal shift register (reg_desp). It accepts one command per REQ: parallel load, shift N positions, or rotate N positions. It then drives the register's MODO/DIR/S_IN/D/ENB pins for exactly the required number of clock edges and reports completion with a one-cycle DONE pulse. It sits between the test/control logic and the register, so the register is never left free-running.

Parameters:
ANCHO, 4, data width of DATO/D (matches the register width)
CNT_W, 3, width of the position count CNT (0..7 positions per command)

Ports:
CLK  input  1  rising-edge clock, shared with the shift register
RST  input  1  asynchronous, active-high reset
REQ  input  1  command request, sampled only in IDLE
OP  input  2  command: 00 shift, 01 rotate, 10 parallel load, 11 treated as load
DIR_IN  input  1  direction for shift/rotate: 0 left, 1 right
CNT  input  CNT_W  number of positions for shift/rotate; ignored for load
DATO  input  ANCHO  load data
S_SER  input  1  serial fill bit used for every step of a shift
BUSY  output  1  command in progress; REQ is ignored while high
DONE  output  1  one-cycle completion pulse
MODO  output  2  to register MODO
DIR  output  1  to register DIR
S_IN  output  1  to register S_IN
ENB  output  1  to register ENB; the register updates only on edges where ENB=1
D  output  ANCHO  to register D

Behaviour:
- All outputs are registered and change only on the CLK rising edge. This keeps them stable across the register's 48 ns internal update delay.
- RST=1 asynchronously forces state IDLE. It also forces BUSY=0, DONE=0, ENB=0, MODO=00, DIR=0, S_IN=0, D=0, and sets the internal counter and command latches to 0.
- States:
  - IDLE: outputs quiescent (ENB=0, DONE=0, BUSY=0).
    - On an edge with REQ=1, latch OP, DIR_IN, CNT, DATO and S_SER and set BUSY=1.
    - If OP is 10 or 11, go to LOAD.
    - Else if CNT=0, go to FIN.
    - Else load counter=CNT and go to STEP.
  - LOAD: ENB=1, MODO=10, D=latched DATO, for exactly one cycle, then go to FIN.
  - STEP: ENB=1, MODO=latched OP (00 or 01), DIR=latched DIR_IN, S_IN=latched S_SER.
    - The counter decrements on each edge.
    - When the counter reaches 1 on an edge, go to FIN.
    - ENB is therefore high for exactly CNT consecutive cycles.
  - FIN: ENB=0, DONE=1 for one cycle, BUSY=1; next state is IDLE.
  - BUSY falls on the edge that leaves FIN.
- Latency: if REQ is accepted at edge k, the register is clocked with ENB=1 on edges k+1..k+N (N=1 for load, CNT otherwise). DONE is high during the cycle after edge k+N. With CNT=0, DONE is high in the cycle after edge k+1 and ENB never rises.
- MODO, DIR, S_IN and D hold their last driven values in IDLE/FIN. Only ENB gates the register.
- REQ held high across completion: a new command is accepted at the first edge in IDLE. The minimum gap between commands is therefore one IDLE cycle after DONE.
- REQ during BUSY is ignored, with no queue. Command inputs may change freely after acceptance.
- RST mid-command: abort immediately. ENB drops asynchronously and no DONE pulse is produced. The register keeps whatever partial result it already has.

Test Plan:
- Reset: assert RST mid-cycle with REQ=1 -> all outputs 0 immediately; no acceptance until RST is released.
- Load: OP=10, DATO=1010 -> ENB=1 for 1 cycle with MODO=10, D=1010; DONE 1 cycle later; register Q=1010; BUSY high for 2 cycles.
- Rotate left: from Q=1010, OP=01, DIR_IN=0, CNT=3 -> ENB high exactly 3 cycles, Q=0101, single DONE pulse.
- Shift right with fill: from Q=0101, OP=00, DIR_IN=1, S_SER=1, CNT=2 -> Q=1010 then 1101; S_IN=1 on both steps.
- Boundaries:
  - CNT=0 shift -> no ENB, DONE in the cycle after acceptance, Q unchanged.
  - CNT=7 rotate -> exactly 7 ENB cycles (counter does not wrap).
  - OP=11 behaves exactly as load.
- Contention/abort:
  - REQ pulsed during STEP -> ignored, the command count is unchanged.
  - RST asserted during STEP of a CNT=5 command -> ENB low at once, no DONE, IDLE afterward.
